// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, fetch defaults and the
// fetch FIFO entry layout.
package cpu_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam word_t      RESET_PC_DEF  = 32'h0000_0000;
  localparam word_t      HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [1:0] FIFO_DEPTH    = 2'd2;

  // One buffered instruction: PC+4 in the upper half, the word below it.
  typedef struct packed {
    word_t pcplus4;
    word_t inst;
  } fetch_entry_t;

  // Byte address to instruction-memory word address.
  function automatic word_t word_addr(input word_t byte_addr);
    return byte_addr >> 2;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response and IF/ID delivery signals of the
// fetch unit. master = fetch unit side, slave = memory / decode side.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic  IMEM_REQ;
  word_t IMEM_ADDR;
  logic  IMEM_VALID;
  word_t IMEM_DATA;
  logic  OUT_VALID;
  logic  OUT_READY;
  word_t INST;
  word_t PCPLUS4;

  modport master (
    output IMEM_REQ, IMEM_ADDR, OUT_VALID, INST, PCPLUS4,
    input  IMEM_VALID, IMEM_DATA, OUT_READY
  );

  modport slave (
    input  IMEM_REQ, IMEM_ADDR, OUT_VALID, INST, PCPLUS4,
    output IMEM_VALID, IMEM_DATA, OUT_READY
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer between memory responses and IF/ID.
// Push and pop on a full buffer both succeed; flush wins over everything.
module fetch_fifo
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic         valid,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push;
  logic         do_pop;

  // Next-state: pointer/occupancy update, flush clears occupancy only.
  always_comb begin
    mem_d   = mem_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    do_pop  = pop && (cnt_q != 2'd0);
    do_push = push && ((cnt_q != FIFO_DEPTH) || do_pop);
    if (flush) begin
      rd_d  = 1'b0;
      wr_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = push_data;
        wr_d        = ~wr_q;
      end
      if (do_pop) begin
        rd_d = ~rd_q;
      end
      cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage and pointers; entries are cleared so the head reads 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign valid = (cnt_q != 2'd0);
  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, two-entry
// buffer toward IF/ID, branch redirect with late-response discard, halt on
// a designated instruction word.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         ENABLE,
  input  logic         REDIRECT,
  input  logic [31:0]  REDIRECT_PC,
  output logic         HALTED,
  fetch_unit_if.master bus
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  logic         out_q, out_d;
  logic         drop_q, drop_d;

  word_t        redir_pc;
  word_t        fetch_pc;
  logic         resp;
  logic         push;
  logic         halt_hit;
  logic         pop;
  logic         issue;
  logic [1:0]   free_slots;

  logic         fifo_valid;
  logic [1:0]   fifo_count;
  fetch_entry_t fifo_head;
  fetch_entry_t push_entry;

  // Request issue, response acceptance and next-state for PC/OUT/DROP/FSM.
  always_comb begin
    redir_pc = REDIRECT_PC & ~32'h0000_0003;
    // A response only counts while a request is outstanding.
    resp     = out_q && bus.IMEM_VALID;
    // A redirect discards a coincident response; DROP discards a stale one.
    push     = resp && !drop_q && !REDIRECT;
    halt_hit = push && (bus.IMEM_DATA == HALT_WORD);
    pop      = fifo_valid && bus.OUT_READY;
    // Slots free after this cycle's flush/pop, before counting a new push.
    free_slots = REDIRECT ? FIFO_DEPTH : (FIFO_DEPTH - fifo_count + {1'b0, pop});
    issue    = RESET && ENABLE && (state_q != ST_HALT) && !halt_hit &&
               (free_slots > {1'b0, out_q}) && (!out_q || bus.IMEM_VALID);
    fetch_pc = REDIRECT ? redir_pc : pc_q;

    // The response's PC+4 is the current PC: PC advanced by 4 when it issued.
    push_entry.pcplus4 = pc_q;
    push_entry.inst    = bus.IMEM_DATA;

    pc_d = pc_q;
    if (issue) begin
      pc_d = fetch_pc + 32'd4;
    end else if (REDIRECT) begin
      pc_d = redir_pc;
    end

    out_d = out_q;
    if (issue) begin
      out_d = 1'b1;
    end else if (resp) begin
      out_d = 1'b0;
    end

    drop_d = drop_q;
    if (resp) begin
      drop_d = 1'b0;
    end else if (REDIRECT && out_q) begin
      drop_d = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ENABLE) state_d = ST_FETCH;
      ST_FETCH: if (halt_hit) state_d = ST_HALT;
      ST_HALT:  if (REDIRECT) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
    if (halt_hit) begin
      state_d = ST_HALT;
    end
  end

  // Control registers; a reset abandons any outstanding request.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      out_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo u_fifo (
    .clk       (CLK),
    .rst_n     (RESET),
    .flush     (REDIRECT),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign bus.IMEM_REQ  = issue;
  assign bus.IMEM_ADDR = issue ? word_addr(fetch_pc) : 32'h0;
  assign bus.OUT_VALID = fifo_valid;
  assign bus.INST      = fifo_head.inst;
  assign bus.PCPLUS4   = fifo_head.pcplus4;
  assign HALTED        = (state_q == ST_HALT);

endmodule
